// File: rtl/hamming74_corrector.sv
// hamming74_corrector
//   Receive-side Hamming(7,4) decoder/corrector for the flash-ADC data path.
//   Two register stages: S1 captures the codeword and parity selection, and S2
//   holds the syndrome, the corrected data and the error flag. Valid/ready
//   handshakes are used on both sides. The block also keeps saturating
//   counters of delivered words and erroneous words.
//
// Ports
//   clk, rst       single clock, asynchronous active-high reset
//   in_valid       codeword present on in_code
//   in_ready       block can accept a codeword this cycle
//   in_code        codeword [7:1], bit n = Hamming position n
//   parity_type    0 = even, 1 = odd; sampled together with in_code
//   out_valid      corrected result present
//   out_ready      downstream accepts the result
//   out_data       corrected data {pos7,pos6,pos5,pos3}
//   out_syndrome   {s4,s2,s1}; nonzero = position that was flipped
//   out_err        syndrome nonzero
//   clr_cnt        synchronous clear of both counters
//   word_cnt       words loaded into the output stage (saturating)
//   err_cnt        loaded words with a nonzero syndrome (saturating)
module hamming74_corrector #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:1]       in_code,
  input  logic             parity_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic       s1_valid;
  logic [7:1] s1_code;
  logic       s1_pt;
  logic       s2_adv;
  logic       in_xfer;
  logic [2:0] syn;
  logic [7:1] fixed;

  // Without a skid buffer, in_ready depends combinationally on out_ready.
  assign s2_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign in_xfer  = in_valid & in_ready;

  // Folding parity_type into each check makes odd parity look like even parity.
  always_comb begin
    syn[0] = ^{s1_code[1], s1_code[3], s1_code[5], s1_code[7], s1_pt};
    syn[1] = ^{s1_code[2], s1_code[3], s1_code[6], s1_code[7], s1_pt};
    syn[2] = ^{s1_code[4], s1_code[5], s1_code[6], s1_code[7], s1_pt};
    fixed  = s1_code;
    for (int k = 1; k <= 7; k++) begin
      if (syn == 3'(k)) fixed[k] = ~s1_code[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_pt    <= 1'b0;
    end else begin
      s1_valid <= in_xfer | (s1_valid & ~s2_adv);
      if (in_xfer) begin
        s1_code <= in_code;
        s1_pt   <= parity_type;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_err      <= 1'b0;
    end else if (s2_adv) begin
      out_valid    <= 1'b1;
      out_data     <= {fixed[7], fixed[6], fixed[5], fixed[3]};
      out_syndrome <= syn;
      out_err      <= (syn != 3'd0);
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else if (clr_cnt) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else if (s2_adv) begin
      if (word_cnt != CNT_MAX) word_cnt <= word_cnt + CNT_ONE;
      if ((syn != 3'd0) && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hamming74_corrector.sv
// tb_hamming74_corrector
//   Directed and random stimulus for hamming74_corrector (CNT_W = 4). The
//   expected outputs come from a reference decoder. That decoder builds the
//   syndrome as the XOR of the positions of all set bits. A queue holds the
//   expected output words in order. The counter model updates when a word is
//   accepted, and the counters are compared against it once the pipe is empty.
module tb_hamming74_corrector;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:1]       in_code;
  logic             parity_type;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic [2:0]       out_syndrome;
  logic             out_err;
  logic             clr_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_cnt;

  int         n_asrt = 0;
  int         n_fail = 0;
  logic [6:0] exp_q[$];
  int         wc = 0;
  int         ec = 0;
  logic       last_acc;

  hamming74_corrector #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .parity_type(parity_type), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_syndrome(out_syndrome),
    .out_err(out_err), .clr_cnt(clr_cnt), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // returns {syndrome[2:0], data[3:0]}
  function automatic logic [6:0] ref_decode(input logic [7:1] c, input logic pt);
    int s;
    logic [7:1] f;
    s = pt ? 7 : 0;
    for (int n = 1; n <= 7; n++) if (c[n]) s = s ^ n;
    f = c;
    if (s != 0) f[s] = ~f[s];
    return {s[2:0], f[7], f[6], f[5], f[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample the handshakes shortly before the edge, update the model, then
  // advance to 1 time unit after the edge.
  task automatic cycle();
    logic [6:0] e;
    #1;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("sb_output_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e[3:0]));
        chk("sb_syndrome", 32'(out_syndrome), 32'(e[6:4]));
        chk("sb_err", 32'(out_err), 32'(e[6:4] != 3'd0));
      end
    end
    if (clr_cnt) begin
      wc = 0;
      ec = 0;
    end
    if (last_acc) begin
      e = ref_decode(in_code, parity_type);
      exp_q.push_back(e);
      if (wc < CMAX) wc++;
      if (e[6:4] != 3'd0 && ec < CMAX) ec++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 40) begin
      cycle();
      g++;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
    chk("word_cnt_model", 32'(word_cnt), 32'(wc));
    chk("err_cnt_model", 32'(err_cnt), 32'(ec));
  endtask

  task automatic directed(input logic [7:1] code, input logic pt,
                          input logic [3:0] ed, input logic [2:0] es);
    in_valid = 1'b1; in_code = code; parity_type = pt; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("lat_not_early", 32'(out_valid), 0);
    cycle();
    chk("lat_valid", 32'(out_valid), 1);
    chk("dir_data", 32'(out_data), 32'(ed));
    chk("dir_syndrome", 32'(out_syndrome), 32'(es));
    chk("dir_err", 32'(out_err), 32'(es != 3'd0));
    drain();
  endtask

  initial begin
    int idx;
    int g;
    logic [7:1] codes[4];

    rst = 1'b1; in_valid = 1'b0; in_code = '0; parity_type = 1'b0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_syndrome", 32'(out_syndrome), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed(7'b1010101, 1'b0, 4'b1011, 3'd0);
    chk("clean_word_cnt", 32'(word_cnt), 1);
    chk("clean_err_cnt", 32'(err_cnt), 0);
    directed(7'b1000101, 1'b0, 4'b1011, 3'd5);
    chk("single_err_cnt", 32'(err_cnt), 1);
    directed(7'b1011110, 1'b1, 4'b1011, 3'd0);
    directed(7'b1011110, 1'b0, 4'b0011, 3'd7);
    directed(7'b0001011, 1'b1, 4'b0000, 3'd0);
    directed(7'b1010100, 1'b0, 4'b1011, 3'd1);

    // backpressure: 4 words offered, output blocked for 5 cycles
    for (int i = 0; i < 4; i++) codes[i] = 7'($urandom);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4);
      in_code = codes[idx % 4];
      parity_type = 1'b0;
      cycle();
      if (last_acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 2);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_out_valid_held", 32'(out_valid), 1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_reopen", 32'(in_ready), 1);
    g = 0;
    while (idx < 4 && g < 20) begin
      in_valid = 1'b1;
      in_code = codes[idx];
      cycle();
      if (last_acc) idx++;
      g++;
    end
    chk("bp_all_accepted", 32'(idx), 4);
    drain();

    // clear coincident with a word advancing into the output stage
    in_valid = 1'b1; in_code = 7'b1000101; parity_type = 1'b0;
    cycle();
    in_valid = 1'b0; clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    chk("clr_word_cnt", 32'(word_cnt), 0);
    chk("clr_err_cnt", 32'(err_cnt), 0);
    drain();

    // saturation: 17 erroneous words
    idx = 0; g = 0;
    while (idx < 17 && g < 60) begin
      in_valid = 1'b1; in_code = 7'b1000101; parity_type = 1'b0;
      cycle();
      if (last_acc) idx++;
      g++;
    end
    drain();
    chk("sat_word_cnt", 32'(word_cnt), 15);
    chk("sat_err_cnt", 32'(err_cnt), 15);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom);
      in_code = 7'($urandom);
      parity_type = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      cycle();
    end
    drain();

    // reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 7'($urandom); parity_type = 1'b0;
    cycle();
    in_code = 7'($urandom);
    cycle();
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_valid", 32'(out_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_word_cnt", 32'(word_cnt), 0);
    chk("arst_err_cnt", 32'(err_cnt), 0);
    chk("arst_out_err", 32'(out_err), 0);
    exp_q.delete();
    wc = 0;
    ec = 0;
    #1 rst = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_no_output", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming74_corrector.md
# hamming74_corrector

Receive-side Hamming(7,4) decoder/corrector for the flash-ADC data path. Accepts 7-bit codewords produced by the encoder (positions [7:1], selectable even/odd parity), computes the syndrome, corrects any single-bit error and delivers the 4-bit ADC sample. It is pipelined with valid/ready handshakes on both sides and keeps saturating word and error statistics.

## Interface
- CNT_W, 16, width of the statistics counters.
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  codeword present on in_code.
- in_ready  output  1  block can accept a codeword this cycle.
- in_code  input  7  codeword [7:1]; bit n = Hamming position n (1,2,4 parity; 3,5,6,7 data).
- parity_type  input  1  0 = even, 1 = odd; sampled with in_code on acceptance.
- out_valid  output  1  corrected result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  4  corrected data {pos7,pos6,pos5,pos3}.
- out_syndrome  output  3  {s4,s2,s1}; nonzero = error position that was flipped.
- out_err  output  1  1 when out_syndrome != 0.
- clr_cnt  input  1  synchronous clear of both counters.
- word_cnt  output  CNT_W  words delivered into output stage, saturating.
- err_cnt  output  CNT_W  words with out_err = 1, saturating.

## Operation
- Transfer occurs on a side when valid & ready are both high at a rising edge.
- Stage 1 (S1): on input transfer, register in_code, parity_type; s1_valid set.
- Stage 2 (S2): on S1→S2 advance, compute syndrome from S1 registers: s1 = c1^c3^c5^c7^pt, s2 = c2^c3^c6^c7^pt, s4 = c4^c5^c6^c7^pt. If syndrome = k (1..7), invert position k; extract data from corrected word. Register out_data, out_syndrome, out_err; out_valid set.
- Syndrome naming an error on a parity position (1,2,4) still counts as error; data unchanged.
- Double-bit errors are not detected; they yield a miscorrected word with out_err = 1 (accepted limitation of 7,4 code).
- Advance rule: s2_adv = s1_valid & (!out_valid | out_ready). in_ready = !s1_valid | s2_adv (combinational from out_ready, no skid buffer).
- out_valid clears on output transfer when no new word advances the same cycle; stays set when both happen.
- Counters increment on s2_adv: word_cnt += 1, err_cnt += 1 if computed syndrome != 0. Both hold at 2^CNT_W−1.
- clr_cnt zeroes both counters; clr_cnt wins over a same-cycle increment.
- Outputs hold stable while out_valid & !out_ready.

## Timing
- Reset (async assert, release sampled at clk): s1_valid = 0, out_valid = 0, out_data = 0, out_syndrome = 0, out_err = 0, word_cnt = 0, err_cnt = 0; in_ready = 1 after reset.
- Latency: input transfer at edge N → out_valid high after edge N+1 (2 registers, in→out 2 cycles) when unstalled.
- Throughput: one word per cycle with out_ready held high.
- Full stall: with out_ready low, accepts exactly 2 words then in_ready = 0; reopening out_ready raises in_ready in the same cycle.
- Reset mid-stream discards S1 and S2 contents; no partial output.

## Test plan
- Even, clean: in_code = 7'b1010101, pt = 0 → out_data = 4'b1011, out_syndrome = 0, out_err = 0, out_valid 2 cycles after transfer; word_cnt = 1, err_cnt = 0.
- Even, single error: in_code = 7'b1000101 (pos5 flipped), pt = 0 → out_data = 4'b1011, out_syndrome = 3'd5, out_err = 1, err_cnt = 1.
- Odd parity: in_code = 7'b1011110, pt = 1 → out_data = 4'b1011, syndrome 0; same word with pt = 0 → syndrome 3'd7, out_data = 4'b0011; in_code = 7'b0001011, pt = 1 → out_data = 0, syndrome 0.
- Backpressure: stream 4 words back-to-back, out_ready low 5 cycles → in_ready low after 2 accepted; release → all 4 delivered in order, none lost or duplicated, word_cnt = 4.
- Counters: CNT_W = 4, send 17 erroneous words → word_cnt = err_cnt = 15; clr_cnt coincident with a word advance → both 0 next cycle.
- Async reset asserted with both stages full → out_valid = 0, counters 0 immediately, in_ready = 1 after release.
